// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: consumes DIGIT bits per clock through a registered
// carry, LSB first, with a start/busy/done handshake and registered result flags.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and divisible by DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_a_sh;
    logic [WIDTH-1:0]       r_b_sh;
    logic [WIDTH-1:0]       r_res_sh;
    logic [WIDTH-1:0]       r_result;
    logic                   r_carry;
    logic                   r_c_out;
    logic                   r_ovf;
    logic [CW-1:0]          r_cnt;
    logic [DIGIT:0]         w_c;
    logic [DIGIT-1:0]       w_sum;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_res_nxt;
    logic                   w_accept;
    logic                   w_last;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == CW'(N - 1));

    // DIGIT chained full-adder stages fed by the registered carry
    always_comb begin
        w_c    = '0;
        w_sum  = '0;
        w_c[0] = r_carry;
        for (int i = 0; i < DIGIT; i++) begin
            w_sum[i]  = r_a_sh[i] ^ r_b_sh[i] ^ w_c[i];
            w_c[i+1]  = (r_a_sh[i] & r_b_sh[i]) | (w_c[i] & (r_a_sh[i] ^ r_b_sh[i]));
        end
    end

    // new sum digits enter at the MSB end; the oldest digit falls off the bottom
    assign w_cat     = {w_sum, r_res_sh};
    assign w_res_nxt = WIDTH'(w_cat >> DIGIT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_c_out  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            // subtraction is a + ~b + 1: invert b and seed the carry with mode
            r_a_sh  <= a;
            r_b_sh  <= mode ? ~b : b;
            r_carry <= mode;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> DIGIT;
            r_b_sh   <= r_b_sh >> DIGIT;
            r_res_sh <= w_res_nxt;
            r_carry  <= w_c[DIGIT];
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_result <= w_res_nxt;
                r_c_out  <= w_c[DIGIT];
                r_ovf    <= w_c[DIGIT] ^ w_c[DIGIT-1];
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign c_out  = r_c_out;
    assign ovf    = r_ovf;

endmodule
